// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned NREGS_DEFAULT  = 32;
  localparam int unsigned NRD_DEFAULT    = 3;

  // Architectural register indices with special meaning.
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h100;

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/writeback/issue logic and the register file.
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned NREGS  = NREGS_DEFAULT,
  parameter int unsigned NRD    = NRD_DEFAULT
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned CW = $clog2(NREGS + 1);

  logic                  we;
  logic [AW-1:0]         wa;
  logic [DATA_W-1:0]     wd;
  logic [NRD*AW-1:0]     ra;
  logic [NRD*DATA_W-1:0] rd;
  logic [NRD-1:0]        busy;
  logic                  issue_valid;
  logic [AW-1:0]         issue_dst;
  logic [CW-1:0]         pending_cnt;

  modport master (
    output we, wa, wd, ra, issue_valid, issue_dst,
    input  rd, busy, pending_cnt
  );

  modport slave (
    input  we, wa, wd, ra, issue_valid, issue_dst,
    output rd, busy, pending_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracker with a running popcount.
// A set and a clear of the same register in one cycle leaves it pending:
// the retiring producer is replaced by the newly issued one.
module regfile_scoreboard #(
  parameter  int unsigned NREGS = 32,
  localparam int unsigned AW    = $clog2(NREGS),
  localparam int unsigned CW    = $clog2(NREGS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  output logic [NREGS-1:0] pending,
  output logic [CW-1:0]    pending_cnt
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             set_ok, clr_ok, inc, dec;

  // Register 0 is never tracked.
  assign set_ok = set_en && (set_idx != '0);
  assign clr_ok = clr_en && (clr_idx != '0);

  // Next pending vector and count; the count only moves on real bit transitions.
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    inc       = set_ok && !pending_q[set_idx];
    dec       = clr_ok && pending_q[clr_idx] && !(set_ok && (set_idx == clr_idx));
    if (clr_ok) pending_d[clr_idx] = 1'b0;
    if (set_ok) pending_d[set_idx] = 1'b1;
    if (inc && !dec) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Scoreboard state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending     = pending_q;
  assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with optional write bypass and a pending-write
// scoreboard for stalling on multicycle producers.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned NREGS   = NREGS_DEFAULT,
  parameter int unsigned NRD     = NRD_DEFAULT,
  parameter int unsigned SP_IDX  = REG_SP,
  parameter logic [63:0] SP_INIT = 64'(SP_INIT_DEFAULT),
  parameter bit          BYPASS  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_sb_if.slave   bus
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [DATA_W-1:0] SpInitW = DATA_W'(SP_INIT);

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [NREGS-1:0]  pending;
  logic [DATA_W-1:0] rd_port [NRD];
  logic [NRD-1:0]    busy_port;

  // Register array; an out-of-range or zero SP_IDX simply gets no init value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= ((i == SP_IDX) && (SP_IDX != REG_ZERO)) ? SpInitW : '0;
      end
    end else if (bus.we && (bus.wa != '0)) begin
      rf_q[bus.wa] <= bus.wd;
    end
  end

  regfile_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (bus.issue_valid),
    .set_idx    (bus.issue_dst),
    .clr_en     (bus.we),
    .clr_idx    (bus.wa),
    .pending    (pending),
    .pending_cnt(bus.pending_cnt)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]     ra_g;
    logic              hit;
    logic [DATA_W-1:0] rd_g;

    assign ra_g = bus.ra[g*AW +: AW];
    assign hit  = BYPASS && bus.we && (bus.wa == ra_g);

    // Read mux: zero register, then in-flight write, then array contents.
    always_comb begin
      rd_g = rf_q[ra_g];
      if (ra_g == '0) begin
        rd_g = '0;
      end else if (hit) begin
        rd_g = bus.wd;
      end
    end

    assign rd_port[g]   = rd_g;
    // A bypassed write satisfies the consumer this cycle, so it is not busy.
    assign busy_port[g] = (ra_g != '0) && pending[ra_g] && !hit;
  end

  // Pack per-port read data onto the bus.
  always_comb begin
    bus.rd = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      bus.rd[i*DATA_W +: DATA_W] = rd_port[i];
    end
  end

  assign bus.busy = busy_port;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build, no-bypass build and a wide
// 16-register four-port build sharing one clock and reset.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(32), .NREGS(32), .NRD(3)) bus_a ();
  regfile_sb_if #(.DATA_W(32), .NREGS(32), .NRD(3)) bus_b ();
  regfile_sb_if #(.DATA_W(64), .NREGS(16), .NRD(4)) bus_c ();

  regfile_sb dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  regfile_sb #(.BYPASS(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  regfile_sb #(
    .DATA_W (64),
    .NREGS  (16),
    .NRD    (4),
    .SP_IDX (13),
    .SP_INIT(64'hFFFF_0000)
  ) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  idst;
    logic [4:0]  ra0;
    logic [31:0] erd;
    logic        ebusy;
    logic [5:0]  ecnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    //          we  wa     wd             iv  idst   ra0    erd            busy cnt
    vecs[0]  = '{1, 5'd0,  32'hDEADBEEF, 1, 5'd0,  5'd0,  32'h0,        0, 6'd0};
    vecs[1]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  32'h0,        0, 6'd0};
    vecs[2]  = '{1, 5'd5,  32'h1234,     0, 5'd0,  5'd5,  32'h1234,     0, 6'd0};
    vecs[3]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd5,  32'h1234,     0, 6'd0};
    vecs[4]  = '{0, 5'd0,  32'h0,        1, 5'd8,  5'd8,  32'h0,        0, 6'd1};
    vecs[5]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd8,  32'h0,        1, 6'd1};
    vecs[6]  = '{1, 5'd8,  32'hAAAA,     0, 5'd0,  5'd8,  32'hAAAA,     0, 6'd0};
    vecs[7]  = '{0, 5'd0,  32'h0,        1, 5'd8,  5'd29, 32'h100,      0, 6'd1};
    vecs[8]  = '{1, 5'd8,  32'hBBBB,     1, 5'd8,  5'd8,  32'hBBBB,     0, 6'd1};
    vecs[9]  = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd8,  32'hBBBB,     1, 6'd1};
    vecs[10] = '{1, 5'd8,  32'hCCCC,     1, 5'd3,  5'd3,  32'h0,        0, 6'd1};
    vecs[11] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd3,  32'h0,        1, 6'd1};
    vecs[12] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd8,  32'hCCCC,     0, 6'd1};
    vecs[13] = '{0, 5'd0,  32'h0,        1, 5'd3,  5'd3,  32'h0,        1, 6'd1};
    vecs[14] = '{1, 5'd3,  32'h3333,     0, 5'd0,  5'd3,  32'h3333,     0, 6'd0};
    vecs[15] = '{1, 5'd8,  32'h4444,     0, 5'd0,  5'd3,  32'h3333,     0, 6'd0};
    vecs[16] = '{1, 5'd31, 32'h7,        1, 5'd31, 5'd31, 32'h7,        0, 6'd1};
    vecs[17] = '{0, 5'd0,  32'h0,        0, 5'd0,  5'd31, 32'h7,        1, 6'd1};

    bus_a.we = 0; bus_a.wa = '0; bus_a.wd = '0; bus_a.ra = '0;
    bus_a.issue_valid = 0; bus_a.issue_dst = '0;
    bus_b.we = 0; bus_b.wa = '0; bus_b.wd = '0; bus_b.ra = '0;
    bus_b.issue_valid = 0; bus_b.issue_dst = '0;
    bus_c.we = 0; bus_c.wa = '0; bus_c.wd = '0; bus_c.ra = '0;
    bus_c.issue_valid = 0; bus_c.issue_dst = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven sequence on the default build.
    for (int i = 0; i < NV; i++) begin
      bus_a.we          = vecs[i].we;
      bus_a.wa          = vecs[i].wa;
      bus_a.wd          = vecs[i].wd;
      bus_a.issue_valid = vecs[i].iv;
      bus_a.issue_dst   = vecs[i].idst;
      bus_a.ra          = {5'd0, 5'd0, vecs[i].ra0};
      #3;
      chk($sformatf("v%0d rd0", i), 64'(bus_a.rd[31:0]), 64'(vecs[i].erd));
      chk($sformatf("v%0d busy0", i), 64'(bus_a.busy[0]), 64'(vecs[i].ebusy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d cnt", i), 64'(bus_a.pending_cnt), 64'(vecs[i].ecnt));
    end
    bus_a.we = 0; bus_a.issue_valid = 0;

    // Async reset mid-cycle with reg 31 pending and holding 7.
    bus_a.ra = {5'd0, 5'd29, 5'd31};
    #2 rst = 1'b1;
    #1;
    chk("async cnt", 64'(bus_a.pending_cnt), 64'd0);
    chk("async busy", 64'(bus_a.busy), 64'd0);
    chk("async rd31", 64'(bus_a.rd[31:0]), 64'd0);
    chk("async rd1 sp", 64'(bus_a.rd[63:32]), 64'h100);
    for (int r = 0; r < 32; r++) begin
      bus_a.ra = {5'd0, 5'd0, 5'(r)};
      #1;
      chk($sformatf("reset r%0d", r), 64'(bus_a.rd[31:0]), (r == 29) ? 64'h100 : 64'd0);
    end
    chk("reset busy", 64'(bus_a.busy), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Write after reset to a non-pending register: no count underflow.
    bus_a.we = 1; bus_a.wa = 5'd8; bus_a.wd = 32'h5A5A; bus_a.ra = {5'd0, 5'd0, 5'd8};
    @(posedge clk);
    #1;
    bus_a.we = 0;
    chk("post-rst cnt", 64'(bus_a.pending_cnt), 64'd0);
    chk("post-rst rd8", 64'(bus_a.rd[31:0]), 64'h5A5A);

    // No-bypass build: old value during the write cycle, new value after.
    bus_b.we = 1; bus_b.wa = 5'd5; bus_b.wd = 32'h1234; bus_b.ra = {5'd0, 5'd0, 5'd5};
    #3;
    chk("nobyp rd pre", 64'(bus_b.rd[31:0]), 64'd0);
    @(posedge clk);
    #1;
    bus_b.we = 0;
    chk("nobyp rd post", 64'(bus_b.rd[31:0]), 64'h1234);
    bus_b.issue_valid = 1; bus_b.issue_dst = 5'd8;
    @(posedge clk);
    #1;
    bus_b.issue_valid = 0;
    bus_b.we = 1; bus_b.wa = 5'd8; bus_b.wd = 32'h55; bus_b.ra = {5'd0, 5'd0, 5'd8};
    #3;
    chk("nobyp busy wr", 64'(bus_b.busy[0]), 64'd1);
    chk("nobyp rd8 wr", 64'(bus_b.rd[31:0]), 64'd0);
    chk("nobyp cnt wr", 64'(bus_b.pending_cnt), 64'd1);
    @(posedge clk);
    #1;
    bus_b.we = 0;
    chk("nobyp busy aft", 64'(bus_b.busy[0]), 64'd0);
    chk("nobyp rd8 aft", 64'(bus_b.rd[31:0]), 64'h55);
    chk("nobyp cnt aft", 64'(bus_b.pending_cnt), 64'd0);

    // Wide build: SP at 13, four independent ports.
    bus_c.ra = {4'd0, 4'd0, 4'd0, 4'd13};
    #1;
    chk("wide sp13", bus_c.rd[63:0], 64'hFFFF_0000);
    for (int r = 1; r <= 4; r++) begin
      bus_c.we = 1; bus_c.wa = 4'(r); bus_c.wd = {32'(r), 32'hC0DE_0000 + 32'(r)};
      @(posedge clk);
      #1;
    end
    bus_c.we = 0;
    bus_c.ra = {4'd4, 4'd3, 4'd2, 4'd1};
    #1;
    chk("wide p0", bus_c.rd[63:0],    64'h0000_0001_C0DE_0001);
    chk("wide p1", bus_c.rd[127:64],  64'h0000_0002_C0DE_0002);
    chk("wide p2", bus_c.rd[191:128], 64'h0000_0003_C0DE_0003);
    chk("wide p3", bus_c.rd[255:192], 64'h0000_0004_C0DE_0004);
    chk("wide cnt", 64'(bus_c.pending_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write, three-read datapath register file.
- Adds the following:
  - configurable data width, register count and read-port count;
  - asynchronous reset with a programmable stack-pointer init value;
  - optional same-cycle write-to-read bypass;
  - a per-register pending-write scoreboard, so the hazard unit can stall on multicycle producers (mult/div, loads).
- Sits in the decode stage: read ports feed operand muxes, the write port is driven by writeback, the issue port is driven by the multicycle issue logic.

Parameters:
DATA_W, 32, register width in bits
NREGS, 32, number of registers; power of two, >= 2
NRD, 3, number of read ports, 1..4
AW, $clog2(NREGS), address width (derived, not overridden)
SP_IDX, 29, index of register given a non-zero reset value
SP_INIT, 32'h100, reset value of register SP_IDX
BYPASS, 1, 1 = write data forwarded combinationally to matching read ports

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
we  in  1  write enable (writeback)
wa  in  AW  write address
wd  in  DATA_W  write data
ra  in  NRD*AW  packed read addresses; port i = ra[i*AW +: AW]
rd  out  NRD*DATA_W  packed read data; port i = rd[i*DATA_W +: DATA_W]
busy  out  NRD  busy[i] = register at read port i has an outstanding write
issue_valid  in  1  a multicycle op that will write issue_dst is issuing
issue_dst  in  AW  destination of the issuing op
pending_cnt  out  $clog2(NREGS+1)  number of registers currently pending

Behaviour:
- Reset (rst high, asynchronous):
  - all registers go to 0, except register SP_IDX, which goes to SP_INIT truncated or zero-extended to DATA_W;
  - all pending bits and pending_cnt go to 0;
  - busy reads 0 and rd reflects the reset contents combinationally.
- Register 0:
  - always reads 0;
  - writes to it are discarded;
  - issue to it is ignored and it is never pending.
  - If SP_IDX == 0, the SP init is ignored.
- Write: on posedge clk with we=1 and wa!=0, rf[wa] <= wd. The value is visible through the array on the next cycle.
- Read: combinational, zero cycles. For each port i:
  - if ra_i == 0, rd_i = 0;
  - else if BYPASS && we && wa == ra_i, rd_i = wd (same cycle);
  - else rd_i = rf[ra_i].
- With BYPASS=0, the value written at edge N is readable only after edge N (the classic write-then-read split is not provided).
- Scoreboard, pending[NREGS-1:0], updated on posedge clk:
  - set: issue_valid && issue_dst != 0 → pending[issue_dst] <= 1;
  - clear: we && wa != 0 → pending[wa] <= 0;
  - same register set and cleared in one cycle: set wins (the new producer is outstanding, the old one has retired);
  - different registers: both actions apply;
  - issue to an already-pending register (WAW): the bit stays 1, and the count does not change.
- busy_i:
  - busy_i = pending[ra_i] && !(BYPASS && we && wa == ra_i);
  - busy_i = 0 for ra_i == 0;
  - a register being written this cycle is not busy if bypass delivers the value.
- pending_cnt:
  - registered; equals popcount(pending) after every edge;
  - increments and decrements follow the set/clear rules above (+1, -1 or 0 per cycle, never both);
  - never exceeds NREGS-1.
- Reset asserted mid-operation clears the scoreboard regardless of in-flight ops. Any write arriving after reset deassertion is accepted normally, with no clear underflow: clearing a non-pending bit is a no-op and the count is unchanged.

Decomposition:
- Shared package holds: default DATA_W/NREGS constants, REG_ZERO=0 and REG_SP=29 index constants, and SP_INIT_DEFAULT.
- The scoreboard (pending vector, set/clear priority, counter) is a natural sub-module, regfile_scoreboard, with ports clk, rst, set_en, set_idx, clr_en, clr_idx, pending, pending_cnt.
- Read-port muxing and bypass stay in regfile_sb, generated per port.

Test Plan:
- Reset check: pulse rst asynchronously mid-cycle, read all 32 registers → reg 29 = 32'h100, all others 0, busy = 0, pending_cnt = 0.
- Zero register: write wa=0, wd=32'hDEADBEEF, then read ra=0; issue_dst=0 → rd = 0, busy = 0, pending_cnt = 0.
- Bypass: same cycle we=1, wa=5, wd=32'h1234 with ra_0=5 → rd_0 = 32'h1234 before the edge. Repeat with BYPASS=0 → rd_0 shows the old value, then 32'h1234 after the edge.
- Scoreboard: issue_dst=8; next cycle ra_1=8 → busy_1 = 1, pending_cnt = 1. Then writeback wa=8 → busy_1 = 0 during the write cycle (bypass), pending_cnt = 0 after the edge.
- Set/clear collision: reg 8 pending, same cycle issue_dst=8 and we wa=8 → pending[8] stays 1, pending_cnt unchanged at 1. Also issue_dst=3 with we wa=8 → count stays 1, reg 3 pending, reg 8 clear.
- Parametrised build: DATA_W=64, NREGS=16, NRD=4, SP_INIT=64'hFFFF_0000 → reset reg 29 wraps out of range. Use SP_IDX=13: reg 13 = 64'hFFFF_0000, four independent read ports return distinct written values.
